// File: rtl/pwm_multi_pipelined_pkg.sv
// Shared types and constants for the multi-channel pipelined PWM.
// cfg_t is sized for the default width/channel count.
package pwm_multi_pkg;

  localparam int W_DEF    = 64;
  localparam int N_DEF    = 4;
  localparam int PIPE_LAT = 2;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_e;

  typedef struct packed {
    logic [W_DEF-1:0]            period;
    logic [N_DEF-1:0][W_DEF-1:0] duty;
    pwm_mode_e                   center;
  } cfg_t;

endpackage

// File: rtl/pwm_multi_pipelined_if.sv
// Control/config/output bundle between the register block, the PWM core
// and the pad stage.
interface pwm_multi_pipelined_if #(
  parameter int W = 64,
  parameter int N = 4
);
  logic           en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [W-1:0]   cfg_period;
  logic [N*W-1:0] cfg_duty;
  logic           cfg_center;
  logic [N-1:0]   pwm_out;
  logic           period_start;

  modport master (
    output en, cfg_valid, cfg_period, cfg_duty, cfg_center,
    input  cfg_ready, pwm_out, period_start
  );

  modport slave (
    input  en, cfg_valid, cfg_period, cfg_duty, cfg_center,
    output cfg_ready, pwm_out, period_start
  );
endinterface

// File: rtl/pwm_multi_pipelined_period_counter.sv
// Shared period counter: edge (sawtooth) or center (triangle) counting.
// wrap flags the edge on which the counter returns to 0, including idle cycles.
module pwm_period_counter
  import pwm_multi_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] period,
  input  pwm_mode_e    mode,
  output logic [W-1:0] count,
  output logic         wrap
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg, count_next;
  logic         dir_down_reg, dir_down_next;

  always_comb begin
    count_next    = '0;
    dir_down_next = 1'b0;
    if (en && (period != '0)) begin
      if (mode == EDGE) begin
        if (count_reg < (period - ONE)) begin
          count_next = count_reg + ONE;
        end
      end else if (!dir_down_reg && (count_reg < period)) begin
        count_next = count_reg + ONE;
      end else if (count_reg > ONE) begin
        // Turning at the peak or descending; reaching 0 restarts upward.
        count_next    = count_reg - ONE;
        dir_down_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      dir_down_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      dir_down_reg <= dir_down_next;
    end
  end

  assign count = count_reg;
  assign wrap  = (count_next == '0);

endmodule

// File: rtl/pwm_multi_pipelined.sv
// N-channel PWM: one shared counter, shadowed config applied only at period
// boundaries, and a 2-stage compare pipeline feeding the outputs.
module pwm_multi_pipelined
  import pwm_multi_pkg::*;
#(
  parameter int W = 64,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_multi_pipelined_if.slave bus
);
  logic [W-1:0] count;
  logic         wrap;
  logic         accept;
  logic         apply;
  logic         run;

  logic         pend_valid_reg;
  logic [W-1:0] pend_period_reg;
  pwm_mode_e    pend_mode_reg;
  logic [W-1:0] pend_duty_reg [N];

  logic [W-1:0] act_period_reg;
  pwm_mode_e    act_mode_reg;
  logic [W-1:0] act_duty_reg [N];

  logic         s1_valid_reg;
  logic         s1_start_reg;
  logic [W-1:0] s1_count_reg;
  logic [W-1:0] s1_duty_reg [N];

  logic         pwm_reg [N];
  logic         start_reg;

  // Accept and apply are exclusive: apply needs a pending entry, accept an empty slot.
  assign accept = bus.cfg_valid && !pend_valid_reg;
  assign apply  = pend_valid_reg && wrap;
  assign run    = bus.en && (act_period_reg != '0);

  assign bus.cfg_ready    = !pend_valid_reg;
  assign bus.period_start = start_reg;

  pwm_period_counter #(.W(W)) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bus.en),
    .period (act_period_reg),
    .mode   (act_mode_reg),
    .count  (count),
    .wrap   (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_reg  <= 1'b0;
      pend_period_reg <= '0;
      pend_mode_reg   <= EDGE;
      act_period_reg  <= '0;
      act_mode_reg    <= EDGE;
      s1_valid_reg    <= 1'b0;
      s1_start_reg    <= 1'b0;
      s1_count_reg    <= '0;
      start_reg       <= 1'b0;
    end else begin
      if (accept) begin
        pend_valid_reg  <= 1'b1;
        pend_period_reg <= bus.cfg_period;
        pend_mode_reg   <= pwm_mode_e'(bus.cfg_center);
      end else if (apply) begin
        pend_valid_reg  <= 1'b0;
      end
      if (apply) begin
        act_period_reg <= pend_period_reg;
        act_mode_reg   <= pend_mode_reg;
      end
      // Counter and active duties move together, so each period sees one config.
      s1_valid_reg <= run;
      s1_start_reg <= run && (count == '0);
      s1_count_reg <= count;
      start_reg    <= s1_start_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_duty_reg[gi] <= '0;
          act_duty_reg[gi]  <= '0;
          s1_duty_reg[gi]   <= '0;
          pwm_reg[gi]       <= 1'b0;
        end else begin
          if (accept) begin
            pend_duty_reg[gi] <= bus.cfg_duty[gi*W +: W];
          end
          if (apply) begin
            act_duty_reg[gi] <= pend_duty_reg[gi];
          end
          s1_duty_reg[gi] <= act_duty_reg[gi];
          pwm_reg[gi]     <= s1_valid_reg && (s1_count_reg < s1_duty_reg[gi]);
        end
      end
      assign bus.pwm_out[gi] = pwm_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_pwm_multi_pipelined.sv
// Bench for pwm_multi_pipelined: table of steady-state configs, hand-written
// handshake/enable/reset sequences, and a random run against a phase-based model.
module tb_pwm_multi_pipelined;
  import pwm_multi_pkg::*;

  localparam int W = 64;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_pipelined_if #(.W(W), .N(N)) bus ();
  pwm_multi_pipelined #(.W(W), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: position in the waveform as a phase index 0..len-1.
  cfg_t        m_act, m_pendc;
  logic        m_pend;
  logic [63:0] m_phase;
  logic [N:0]  m_d1, m_exp;

  task automatic model_reset();
    m_act = '0; m_pendc = '0; m_pend = 1'b0;
    m_phase = '0; m_d1 = '0; m_exp = '0;
  endtask

  task automatic model_step();
    logic [63:0] len, cval;
    logic [N:0]  now;
    logic        wrapped;
    len  = (m_act.center == CENTER) ? 2 * m_act.period : m_act.period;
    cval = (m_act.center == CENTER && m_phase > m_act.period) ? len - m_phase : m_phase;
    now  = '0;
    if (bus.en && m_act.period != 0) begin
      now[N] = (m_phase == 0);
      for (int i = 0; i < N; i++) now[i] = (cval < m_act.duty[i]);
    end
    m_exp = m_d1;
    m_d1  = now;
    if (!bus.en || m_act.period == 0) m_phase = 0;
    else m_phase = (m_phase + 1) % len;
    wrapped = (m_phase == 0);
    if (m_pend && wrapped) begin
      m_act  = m_pendc;
      m_pend = 1'b0;
    end else if (bus.cfg_valid && !m_pend) begin
      m_pendc.period = bus.cfg_period;
      m_pendc.duty   = bus.cfg_duty;
      m_pendc.center = pwm_mode_e'(bus.cfg_center);
      m_pend = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      if (rst_n) check("cycle{ready,start,pwm}",
                       {bus.cfg_ready, bus.period_start, bus.pwm_out}, {!m_pend, m_exp});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  function automatic cfg_t mk_cfg(input logic [63:0] p, input logic [63:0] d0, input logic [63:0] d1,
                                  input logic [63:0] d2, input logic [63:0] d3, input logic c);
    mk_cfg.period = p;
    mk_cfg.duty   = {d3, d2, d1, d0};
    mk_cfg.center = pwm_mode_e'(c);
  endfunction

  typedef struct packed {
    cfg_t                 cfg;
    logic [N-1:0][15:0]   exp_high;
    logic [15:0]          exp_starts;
    logic [15:0]          window;
  } vec_t;

  vec_t vecs [7];

  task automatic wait_ready();
    int k = 0;
    while (!bus.cfg_ready && k < 400) begin @(negedge clk); k++; end
    check("ready_wait", bus.cfg_ready, 1);
  endtask

  task automatic wait_start();
    int k = 0;
    do begin @(posedge clk); #1; k++; end while (!bus.period_start && k < 400);
    check("start_wait", bus.period_start, 1);
  endtask

  task automatic drive_cfg(input cfg_t c);
    bus.cfg_period = c.period;
    bus.cfg_duty   = c.duty;
    bus.cfg_center = c.center;
  endtask

  // Load through the idle path (en=0 applies on the next cycle), then run.
  task automatic load_cfg(input cfg_t c);
    @(negedge clk); bus.en = 1'b0;
    wait_ready();
    drive_cfg(c); bus.cfg_valid = 1'b1;
    @(negedge clk); bus.cfg_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.en = 1'b1;
  endtask

  initial begin
    int          cnt [N];
    int          starts, k;
    logic [63:0] p, d [N];

    bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_period = '0;
    bus.cfg_duty = '0; bus.cfg_center = 1'b0;

    vecs[0] = '{cfg: mk_cfg(100, 0, 50, 100, 200, 0), exp_high: {16'd100, 16'd100, 16'd50, 16'd0}, exp_starts: 1, window: 100};
    vecs[1] = '{cfg: mk_cfg(100, 0, 50, 100, 101, 1), exp_high: {16'd200, 16'd199, 16'd99, 16'd0}, exp_starts: 1, window: 200};
    vecs[2] = '{cfg: mk_cfg(1, 0, 1, 2, 0, 0),        exp_high: {16'd0, 16'd1, 16'd1, 16'd0},       exp_starts: 1, window: 1};
    vecs[3] = '{cfg: mk_cfg(1, 1, 2, 0, 1, 1),        exp_high: {16'd1, 16'd0, 16'd2, 16'd1},       exp_starts: 1, window: 2};
    vecs[4] = '{cfg: mk_cfg(7, 3, 6, 7, '1, 0),       exp_high: {16'd7, 16'd7, 16'd6, 16'd3},       exp_starts: 1, window: 7};
    vecs[5] = '{cfg: mk_cfg(5, 3, 5, 6, 1, 1),        exp_high: {16'd1, 16'd10, 16'd9, 16'd5},      exp_starts: 1, window: 10};
    vecs[6] = '{cfg: mk_cfg(0, 1, 5, '1, 0, 0),       exp_high: {16'd0, 16'd0, 16'd0, 16'd0},       exp_starts: 0, window: 10};

    repeat (3) @(negedge clk);
    check("reset_pwm", bus.pwm_out, 0);
    check("reset_start", bus.period_start, 0);
    check("reset_ready", bus.cfg_ready, 1);
    rst_n = 1'b1;

    // Steady-state high counts over one full waveform period.
    for (int r = 0; r < 7; r++) begin
      load_cfg(vecs[r].cfg);
      repeat (4) @(negedge clk);
      for (int i = 0; i < N; i++) cnt[i] = 0;
      starts = 0;
      for (int c = 0; c < int'(vecs[r].window); c++) begin
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) cnt[i] += int'(bus.pwm_out[i]);
        starts += int'(bus.period_start);
      end
      for (int i = 0; i < N; i++)
        check($sformatf("row%0d_ch%0d_high", r, i), cnt[i], vecs[r].exp_high[i]);
      check($sformatf("row%0d_starts", r), starts, vecs[r].exp_starts);
      $display("row %0d: P=%0d center=%0d highs=%0d,%0d,%0d,%0d starts=%0d",
               r, vecs[r].cfg.period, vecs[r].cfg.center, cnt[0], cnt[1], cnt[2], cnt[3], starts);
    end

    // Mid-period update at counter=30, with a second offer while pending.
    load_cfg(mk_cfg(100, 0, 50, 100, 200, 0));
    wait_start();
    repeat (28) @(posedge clk);
    @(negedge clk); drive_cfg(mk_cfg(50, 0, 25, 100, 200, 0)); bus.cfg_valid = 1'b1;
    @(negedge clk);
    check("mid_ready_drop", bus.cfg_ready, 0);
    drive_cfg(mk_cfg(7, 1, 2, 3, 4, 1));
    repeat (3) begin @(negedge clk); check("mid_ready_held", bus.cfg_ready, 0); end
    bus.cfg_valid = 1'b0;
    k = 4;
    while (!bus.cfg_ready && k < 300) begin @(negedge clk); k++; end
    check("mid_ready_rise_cycle", k, 70);
    repeat (4) @(negedge clk);
    cnt[1] = 0;
    for (int c = 0; c < 50; c++) begin @(posedge clk); #1; cnt[1] += int'(bus.pwm_out[1]); end
    check("mid_new_ch1_high", cnt[1], 25);
    $display("mid-period update: ready low %0d cycles, new ch1 high %0d/50", k, cnt[1]);

    // Accept on the wrap cycle lands one full period later.
    wait_start();
    repeat (47) @(posedge clk);
    @(negedge clk); drive_cfg(mk_cfg(20, 5, 10, 20, 0, 0)); bus.cfg_valid = 1'b1;
    @(negedge clk); bus.cfg_valid = 1'b0;
    k = 1;
    while (!bus.cfg_ready && k < 300) begin @(negedge clk); k++; end
    check("wrap_accept_ready_rise_cycle", k, 51);
    $display("wrap-cycle accept: ready low until edge %0d", k);

    // en low at counter=40, then re-enable.
    load_cfg(mk_cfg(100, 0, 50, 100, 200, 0));
    wait_start();
    repeat (38) @(posedge clk);
    @(negedge clk); bus.en = 1'b0;
    repeat (PIPE_LAT) @(posedge clk);
    #1;
    check("en_low_pwm", bus.pwm_out, 0);
    check("en_low_start", bus.period_start, 0);
    k = 0;
    repeat (5) begin @(posedge clk); #1; k += int'(bus.pwm_out != 0); end
    check("en_low_stays_low", k, 0);
    @(negedge clk); bus.en = 1'b1;
    @(posedge clk); #1; check("reen_start_early", bus.period_start, 0);
    @(posedge clk); #1; check("reen_start_lat2", bus.period_start, 1);
    cnt[1] = int'(bus.pwm_out[1]);
    repeat (99) begin @(posedge clk); #1; cnt[1] += int'(bus.pwm_out[1]); end
    check("reen_first_pulse_ch1", cnt[1], 50);
    $display("en toggle: first period ch1 high %0d/100", cnt[1]);

    // Async reset mid-period with a pending config.
    wait_start();
    repeat (20) @(posedge clk);
    @(negedge clk); drive_cfg(mk_cfg(30, 10, 10, 10, 10, 0)); bus.cfg_valid = 1'b1;
    @(negedge clk); bus.cfg_valid = 1'b0;
    check("rst_pending_ready", bus.cfg_ready, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_pwm", bus.pwm_out, 0);
    check("rst_async_start", bus.period_start, 0);
    check("rst_async_ready", bus.cfg_ready, 1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    k = 0;
    repeat (20) begin @(posedge clk); #1; k += int'(bus.pwm_out != 0) + int'(bus.period_start); end
    check("rst_p0_idle_outputs", k, 0);
    $display("reset mid-period: post-release activity %0d", k);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      bus.en        = ($urandom_range(0, 39) != 0);
      bus.cfg_valid = ($urandom_range(0, 14) == 0);
      p = 64'($urandom_range(0, 12));
      for (int i = 0; i < N; i++)
        d[i] = ($urandom_range(0, 7) == 0) ? '1 : 64'($urandom_range(0, 32'(p) + 2));
      drive_cfg(mk_cfg(p, d[0], d[1], d[2], d[3], 1'($urandom_range(0, 1))));
    end
    @(negedge clk); bus.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
